// File: rtl/legv8_multicycle_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control FSM: state codes, opcode
// match patterns, datapath mux/ALU codes and the decoded-class / control bundles.
package legv8_multicycle_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_ALU_WB = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_LD_WB  = 4'd6;
    localparam logic [3:0] S_MEM_WR = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ERROR  = 4'd10;

    localparam logic [10:0] OP_ADD      = 11'b10001011000;
    localparam logic [10:0] OP_SUB      = 11'b11001011000;
    localparam logic [10:0] OP_AND      = 11'b10001010000;
    localparam logic [10:0] OP_ORR      = 11'b10101010000;
    localparam logic [10:0] OP_LDUR     = 11'b11111000010;
    localparam logic [10:0] OP_STUR     = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI_PFX = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX    = 6'b000101;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_PASS_B = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    typedef struct packed {
        logic rtype;
        logic addi;
        logic ldur;
        logic stur;
        logic cbz;
        logic b;
        logic illegal;
    } inst_class_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       ior_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic       reg2loc;
        logic       reg_write;
        logic       memto_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
        logic       err;
    } ctrl_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_inst_class.sv
// Combinational opcode classifier: maps IR[31:21] to a one-hot instruction class.
module legv8_inst_class
    import legv8_multicycle_ctrl_pkg::*;
(
    input  logic [10:0]  opcode,
    output inst_class_t  cls
);

    // NOTE: every field gets a default first so no path through the block can infer a latch.
    always_comb begin
        cls       = '0;
        cls.rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_ORR);
        cls.addi  = (opcode[10:1] == OP_ADDI_PFX);
        cls.ldur  = (opcode == OP_LDUR);
        cls.stur  = (opcode == OP_STUR);
        cls.cbz   = (opcode[10:3] == OP_CBZ_PFX);
        cls.b     = (opcode[10:5] == OP_B_PFX);
        cls.illegal = !(cls.rtype || cls.addi || cls.ldur || cls.stur || cls.cbz || cls.b);
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: steps the shared datapath through fetch, decode,
// execute, memory and write-back, with a memory-ready timeout and a sticky error state.
module legv8_multicycle_ctrl
    import legv8_multicycle_ctrl_pkg::*;
#(
    parameter int OPW     = 11,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ior_d,
    output logic           ir_write,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           pc_src,
    output logic           reg2loc,
    output logic           reg_write,
    output logic           memto_reg,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           retire,
    output logic           err
);

    localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT - 1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          waiting, timeout_hit;
    inst_class_t   cls;
    ctrl_t         ctrl;

    legv8_inst_class u_inst_class (
        .opcode (opcode),
        .cls    (cls)
    );

    assign waiting     = !mem_ready &&
                         ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR));
    assign timeout_hit = waiting && (wait_cnt_q == WAIT_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (cls.illegal)                  state_d = S_ERROR;
                else if (cls.rtype || cls.addi)   state_d = S_EXEC;
                else if (cls.ldur || cls.stur)    state_d = S_ADDR;
                else if (cls.cbz)                 state_d = S_BRANCH;
                else                              state_d = S_JUMP;
            end
            S_EXEC:   state_d = S_ALU_WB;
            S_ALU_WB: state_d = S_FETCH;
            S_ADDR:   state_d = cls.ldur ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_d = S_LD_WB;
            S_LD_WB:  state_d = S_FETCH;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
        // A ready in the final allowed wait cycle never reaches here, so it still wins.
        if (timeout_hit) state_d = S_ERROR;
        wait_cnt_d = (waiting && !timeout_hit) ? wait_cnt_q + CW'(1) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.reg2loc   = cls.stur || cls.cbz;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = cls.addi ? SRCB_IMM : SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_LD_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.memto_reg = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
                ctrl.reg2loc   = 1'b1;
                ctrl.retire    = mem_ready;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_PASS_B;
                ctrl.reg2loc       = 1'b1;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = 1'b1;
                ctrl.retire        = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_ERROR: ctrl.err = 1'b1;
            default: ctrl.err = 1'b1;
        endcase
        // Reset silences every strobe immediately, not just from the next edge.
        if (rst) ctrl = '0;
    end

    assign mem_req       = ctrl.mem_req;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ior_d         = ctrl.ior_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_src        = ctrl.pc_src;
    assign reg2loc       = ctrl.reg2loc;
    assign reg_write     = ctrl.reg_write;
    assign memto_reg     = ctrl.memto_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign retire        = ctrl.retire;
    assign err           = ctrl.err;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl (TIMEOUT=4): per-cycle output vectors are
// compared against hand-written expectations for every instruction class and error path.
module tb_legv8_multicycle_ctrl;

    // Output vector order: mem_req mem_read mem_write ior_d ir_write pc_write pc_write_cond
    // pc_src reg2loc reg_write memto_reg alu_src_a alu_src_b[2] alu_op[2] retire err
    localparam logic [17:0] V_ZERO       = 18'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] V_FETCH_RDY  = 18'b1_1_0_0_1_1_0_0_0_0_0_0_01_00_0_0;
    localparam logic [17:0] V_FETCH_WAIT = 18'b1_1_0_0_0_0_0_0_0_0_0_0_01_00_0_0;
    localparam logic [17:0] V_DEC        = 18'b0_0_0_0_0_0_0_0_0_0_0_0_11_00_0_0;
    localparam logic [17:0] V_DEC_R2L    = 18'b0_0_0_0_0_0_0_0_1_0_0_0_11_00_0_0;
    localparam logic [17:0] V_EXEC_R     = 18'b0_0_0_0_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam logic [17:0] V_EXEC_I     = 18'b0_0_0_0_0_0_0_0_0_0_0_1_10_10_0_0;
    localparam logic [17:0] V_ALU_WB     = 18'b0_0_0_0_0_0_0_0_0_1_0_0_00_00_1_0;
    localparam logic [17:0] V_ADDR       = 18'b0_0_0_0_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [17:0] V_MEM_RD     = 18'b1_1_0_1_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] V_LD_WB      = 18'b0_0_0_0_0_0_0_0_0_1_1_0_00_00_1_0;
    localparam logic [17:0] V_MEMWR_WAIT = 18'b1_0_1_1_0_0_0_0_1_0_0_0_00_00_0_0;
    localparam logic [17:0] V_MEMWR_RDY  = 18'b1_0_1_1_0_0_0_0_1_0_0_0_00_00_1_0;
    localparam logic [17:0] V_BRANCH     = 18'b0_0_0_0_0_0_1_1_1_0_0_1_00_01_1_0;
    localparam logic [17:0] V_JUMP       = 18'b0_0_0_0_0_1_0_1_0_0_0_0_00_00_1_0;
    localparam logic [17:0] V_ERROR      = 18'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_0_1;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_ADDI = 11'b10010001001;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_CBZ  = 11'b10110100101;
    localparam logic [10:0] T_B    = 11'b00010110011;
    localparam logic [10:0] T_BAD  = 11'b11111111111;
    localparam logic [10:0] T_NEAR = 11'b10101010001;

    logic        clk, rst, mem_ready;
    logic [10:0] opcode;
    logic        mem_req, mem_read, mem_write, ior_d, ir_write, pc_write, pc_write_cond;
    logic        pc_src, reg2loc, reg_write, memto_reg, alu_src_a, retire, err;
    logic [1:0]  alu_src_b, alu_op;
    int          total, bad;

    legv8_multicycle_ctrl #(.OPW(11), .TIMEOUT(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .ior_d(ior_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .reg2loc(reg2loc), .reg_write(reg_write), .memto_reg(memto_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .retire(retire), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] outs();
        return {mem_req, mem_read, mem_write, ior_d, ir_write, pc_write, pc_write_cond,
                pc_src, reg2loc, reg_write, memto_reg, alu_src_a, alu_src_b, alu_op,
                retire, err};
    endfunction

    task automatic do_reset(input logic [10:0] op);
        rst = 1'b1;
        opcode = op;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = T_ADD;
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = outs();
            total++;
            if (obs !== V_ZERO) begin
                $display("FAIL reset cycle %0d: got %b want %b", i, obs, V_ZERO);
                bad++;
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [17:0] exp_v [5];
        logic        rdy_v [5];
        logic [17:0] obs;
        exp_v = '{V_FETCH_RDY, V_DEC, V_EXEC_R, V_ALU_WB, V_FETCH_WAIT};
        rdy_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = T_ADD;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy_v[i];
            #1;
            obs = outs();
            total++;
            if (obs !== exp_v[i]) begin
                $display("FAIL add cycle %0d: got %b want %b", i + 1, obs, exp_v[i]);
                bad++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rtype_addi();
        logic [10:0] ops [4];
        logic [17:0] obs, exp_v;
        ops = '{T_SUB, T_AND, T_ORR, T_ADDI};
        for (int k = 0; k < 4; k++) begin
            do_reset(ops[k]);
            mem_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                case (i)
                    0: exp_v = V_FETCH_RDY;
                    1: exp_v = V_DEC;
                    2: exp_v = (k == 3) ? V_EXEC_I : V_EXEC_R;
                    default: exp_v = V_ALU_WB;
                endcase
                #1;
                obs = outs();
                total++;
                if (obs !== exp_v) begin
                    $display("FAIL rtype_addi op=%b cycle %0d: got %b want %b", ops[k], i + 1, obs, exp_v);
                    bad++;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_ldur();
        logic [17:0] exp_v [8];
        logic        rdy_v [8];
        logic [17:0] obs;
        exp_v = '{V_FETCH_RDY, V_DEC, V_ADDR, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_LD_WB};
        rdy_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset(T_LDUR);
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy_v[i];
            #1;
            obs = outs();
            total++;
            if (obs !== exp_v[i]) begin
                $display("FAIL ldur cycle %0d: got %b want %b", i + 1, obs, exp_v[i]);
                bad++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stur_branch_jump();
        logic [10:0] ops [3];
        logic [17:0] exp_v [3][5];
        logic        rdy_v [5];
        int          len [3];
        logic [17:0] obs;
        ops   = '{T_STUR, T_CBZ, T_B};
        exp_v = '{'{V_FETCH_RDY, V_DEC_R2L, V_ADDR, V_MEMWR_RDY, V_FETCH_WAIT},
                  '{V_FETCH_RDY, V_DEC_R2L, V_BRANCH, V_FETCH_WAIT, V_ZERO},
                  '{V_FETCH_RDY, V_DEC, V_JUMP, V_FETCH_WAIT, V_ZERO}};
        len   = '{5, 4, 4};
        for (int k = 0; k < 3; k++) begin
            do_reset(ops[k]);
            rdy_v = '{1'b1, 1'b0, 1'b0, (k == 0) ? 1'b1 : 1'b0, 1'b0};
            for (int i = 0; i < len[k]; i++) begin
                mem_ready = rdy_v[i];
                #1;
                obs = outs();
                total++;
                if (obs !== exp_v[k][i]) begin
                    $display("FAIL seq op=%b cycle %0d: got %b want %b", ops[k], i + 1, obs, exp_v[k][i]);
                    bad++;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_illegal();
        logic [10:0] ops [2];
        logic [17:0] obs, exp_v;
        ops = '{T_BAD, T_NEAR};
        for (int k = 0; k < 2; k++) begin
            do_reset(ops[k]);
            for (int i = 0; i < 22; i++) begin
                mem_ready = (i == 0) ? 1'b1 : 1'(i % 2);
                exp_v = (i == 0) ? V_FETCH_RDY : (i == 1) ? V_DEC : V_ERROR;
                #1;
                obs = outs();
                total++;
                if (obs !== exp_v) begin
                    $display("FAIL illegal op=%b cycle %0d: got %b want %b", ops[k], i + 1, obs, exp_v);
                    bad++;
                end
                @(posedge clk);
                #1;
            end
            rst = 1'b1;
            #1;
            obs = outs();
            total++;
            if (obs !== V_ZERO) begin
                $display("FAIL illegal_rst: got %b want %b", obs, V_ZERO);
                bad++;
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
            mem_ready = 1'b0;
            #1;
            obs = outs();
            total++;
            if (obs !== V_FETCH_WAIT) begin
                $display("FAIL illegal_release: got %b want %b", obs, V_FETCH_WAIT);
                bad++;
            end
        end
    endtask

    task automatic test_timeout();
        logic [17:0] exp_v [3][9];
        logic        rdy_v [3][9];
        logic [10:0] ops [3];
        int          len [3];
        logic [17:0] obs;
        ops   = '{T_ADD, T_ADD, T_STUR};
        len   = '{5, 6, 8};
        exp_v = '{'{V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT, V_ERROR,
                    V_ZERO, V_ZERO, V_ZERO, V_ZERO},
                  '{V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_RDY, V_DEC, V_EXEC_R,
                    V_ZERO, V_ZERO, V_ZERO},
                  '{V_FETCH_RDY, V_DEC_R2L, V_ADDR, V_MEMWR_WAIT, V_MEMWR_WAIT, V_MEMWR_WAIT,
                    V_MEMWR_WAIT, V_ERROR, V_ZERO}};
        rdy_v = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        for (int k = 0; k < 3; k++) begin
            do_reset(ops[k]);
            for (int i = 0; i < len[k]; i++) begin
                mem_ready = rdy_v[k][i];
                #1;
                obs = outs();
                total++;
                if (obs !== exp_v[k][i]) begin
                    $display("FAIL timeout run %0d cycle %0d: got %b want %b", k, i + 1, obs, exp_v[k][i]);
                    bad++;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [17:0] exp_v [8];
        logic        rdy_v [8];
        logic        rst_v [8];
        logic [17:0] obs;
        exp_v = '{V_FETCH_RDY, V_DEC_R2L, V_ADDR, V_MEMWR_WAIT, V_MEMWR_WAIT, V_ZERO, V_ZERO, V_FETCH_WAIT};
        rdy_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        rst_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset(T_STUR);
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy_v[i];
            rst = rst_v[i];
            #1;
            obs = outs();
            total++;
            if (obs !== exp_v[i]) begin
                $display("FAIL rst_mid cycle %0d: got %b want %b", i + 1, obs, exp_v[i]);
                bad++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_add();
        test_rtype_addi();
        test_ldur();
        test_stur_branch_jump();
        test_illegal();
        test_timeout();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
